// File: rtl/run_monitor.sv
// Execution monitor for the pipelined CPU. It checks the PC after reset, then counts run cycles and retires until halt or timeout, and latches a sticky verdict.
// Latency: every output is registered and updates on the edge after its cause. The PC verdict lands on edge RST_DELAY after reset and the halt verdict on the halt edge.
// Backpressure: none; the block passively observes pc/halt/retire and never stalls the CPU.
// Optional build macro HALT_PC_CHECK_EN: when defined, a halt also requires pc == EXPECTED_HALT_PC.
module run_monitor #(
    parameter int              PC_W             = 9,
    parameter int              CNT_W            = 16,
    parameter logic [PC_W-1:0] RESET_PC         = '0,
    parameter int              RST_DELAY        = 1,     // minimum 1
    parameter int              MAX_CYCLES       = 1000,  // at most 2^CNT_W-1
    parameter logic [PC_W-1:0] EXPECTED_HALT_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PC_W-1:0]  pc,
    input  logic             halt,
    input  logic             retire,
    output logic [2:0]       state,
    output logic             done,
    output logic             pass,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count
);

    typedef enum logic [2:0] {
        S_WAIT = 3'd1,
        S_RUN  = 3'd2,
        S_PASS = 3'd3,
        S_FAIL = 3'd4
    } state_e;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_PC      = 3'd1;
    localparam logic [2:0] ERR_TIMEOUT = 3'd2;
    localparam logic [2:0] ERR_HALT_PC = 3'd3;

    // The delay counter only has to reach RST_DELAY before WAIT is left.
    localparam int              DLY_W    = (RST_DELAY < 2) ? 1 : $clog2(RST_DELAY + 1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(RST_DELAY - 1);

    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] CYC_MAX  = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ALL  = '1;

`ifdef HALT_PC_CHECK_EN
    localparam bit CHECK_HALT_PC = 1'b1;
`else
    localparam bit CHECK_HALT_PC = 1'b0;
`endif

    state_e           state_q, state_d;
    logic [2:0]       err_q, err_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] ret_q, ret_d;
    logic [DLY_W-1:0] dly_q, dly_d;

    logic [CNT_W-1:0] cyc_inc;
    logic [CNT_W-1:0] ret_inc;
    logic             halt_pc_bad;

    // Saturating increments, so the counters never wrap. Also the halt PC comparison, which is constant-false unless the check is built in.
    always_comb begin
        cyc_inc     = (cyc_q == CNT_ALL) ? cyc_q : cyc_q + 1'b1;
        ret_inc     = (ret_q == CNT_ALL) ? ret_q : ret_q + 1'b1;
        halt_pc_bad = CHECK_HALT_PC && (pc != EXPECTED_HALT_PC);
    end

    // State register. Reset overrides everything, including a latched verdict.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_WAIT;
            err_q   <= ERR_NONE;
            cyc_q   <= '0;
            ret_q   <= '0;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            cyc_q   <= cyc_d;
            ret_q   <= ret_d;
            dly_q   <= dly_d;
        end
    end

    // Next-state logic. In RUN, halt takes priority over timeout, and timeout over normal counting.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        cyc_d   = cyc_q;
        ret_d   = ret_q;
        dly_d   = dly_q;
        case (state_q)
            S_WAIT: begin
                // halt/retire are ignored until the CPU has had time to reset.
                dly_d = dly_q + 1'b1;
                if (dly_q == DLY_LAST) begin
                    if (pc == RESET_PC) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_FAIL;
                        err_d   = ERR_PC;
                    end
                end
            end
            S_RUN: begin
                if (halt) begin
                    cyc_d = cyc_inc;
                    if (retire) begin
                        ret_d = ret_inc;
                    end
                    if (halt_pc_bad) begin
                        state_d = S_FAIL;
                        err_d   = ERR_HALT_PC;
                    end else begin
                        state_d = S_PASS;
                    end
                end else if (cyc_q == CYC_LAST) begin
                    // A retire on the timeout edge is deliberately not counted.
                    state_d = S_FAIL;
                    err_d   = ERR_TIMEOUT;
                    cyc_d   = CYC_MAX;
                end else begin
                    cyc_d = cyc_inc;
                    if (retire) begin
                        ret_d = ret_inc;
                    end
                end
            end
            S_PASS, S_FAIL: begin
                // Verdict and counters frozen until reset.
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    assign state        = state_q;
    assign done         = (state_q == S_PASS) || (state_q == S_FAIL);
    assign pass         = (state_q == S_PASS);
    assign err_code     = err_q;
    assign cycle_count  = cyc_q;
    assign retire_count = ret_q;

endmodule

// File: tb/tb_run_monitor.sv
module tb_run_monitor;

    localparam int RD   = 3;
    localparam int MAXC = 20;
    localparam logic [8:0] HALT_PC_OK = 9'h00C;
`ifdef HALT_PC_CHECK_EN
    localparam bit HPC = 1'b1;
`else
    localparam bit HPC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [8:0]  pc = '0;
    logic        halt = 1'b0;
    logic        retire = 1'b0;
    logic [2:0]  state;
    logic        done;
    logic        pass;
    logic [2:0]  err_code;
    logic [15:0] cycle_count;
    logic [15:0] retire_count;

    always #5 clk = ~clk;

    run_monitor #(
        .PC_W(9), .CNT_W(16), .RESET_PC(9'h000), .RST_DELAY(RD),
        .MAX_CYCLES(MAXC), .EXPECTED_HALT_PC(HALT_PC_OK)
    ) dut (
        .clk(clk), .reset(reset), .pc(pc), .halt(halt), .retire(retire),
        .state(state), .done(done), .pass(pass), .err_code(err_code),
        .cycle_count(cycle_count), .retire_count(retire_count)
    );

    typedef struct {
        logic [2:0] st;
        logic [2:0] err;
        int         cyc;
        int         ret;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic done_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: on each new verdict, pop the expected result and compare.
    always @(negedge clk) begin
        if (done === 1'b1 && done_prev === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_verdict: state %0d with no verdict expected (t=%0t)", state, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("verdict_state", 32'(state), 32'(mon_e.st));
                check("verdict_pass", 32'(pass), 32'(mon_e.st == 3'd3));
                check("verdict_err", 32'(err_code), 32'(mon_e.err));
                check("verdict_cycles", 32'(cycle_count), mon_e.cyc);
                check("verdict_retires", 32'(retire_count), mon_e.ret);
            end
        end
        done_prev = done;
    end

    // One scenario: reset, WAIT with pc check, RUN until verdict or abort.
    // abort_at > 0 means reset is applied after that many RUN edges.
    task automatic run_scn(input logic [8:0] chk_pc, input int halt_edge,
                           input logic [8:0] halt_pc, input int abort_at, input bit alt_ret);
        exp_t v;
        int   ret_sum = 0;
        bit   got = 0;
        bit   h;
        bit   r;
        v = '{st: 3'd0, err: 3'd0, cyc: 0, ret: 0};

        reset = 1'b1; pc = 9'($urandom); halt = 1'($urandom); retire = 1'($urandom);
        @(posedge clk); #1;
        check("reset_state", 32'(state), 32'd1);
        check("reset_done", 32'(done), 32'd0);
        check("reset_pass", 32'(pass), 32'd0);
        check("reset_err", 32'(err_code), 32'd0);
        check("reset_cycles", 32'(cycle_count), 32'd0);
        check("reset_retires", 32'(retire_count), 32'd0);
        reset = 1'b0;

        for (int e = 1; e <= RD; e++) begin
            pc = (e == RD) ? chk_pc : 9'($urandom_range(1, 511));
            halt = 1'($urandom); retire = 1'($urandom);
            if (e == RD && chk_pc != 9'h000) begin
                v = '{st: 3'd4, err: 3'd1, cyc: 0, ret: 0};
                exp_q.push_back(v);
                got = 1;
            end
            @(posedge clk); #1;
            if (e < RD) check("wait_state", 32'(state), 32'd1);
        end

        if (!got) begin
            for (int k = 1; k <= MAXC + 1; k++) begin
                if (abort_at > 0 && k > abort_at) break;
                h = (k == halt_edge);
                r = alt_ret ? bit'(k % 2) : 1'($urandom);
                halt = h; retire = r;
                pc = h ? halt_pc : 9'($urandom);
                if (h) begin
                    v.st  = (HPC && halt_pc != HALT_PC_OK) ? 3'd4 : 3'd3;
                    v.err = (HPC && halt_pc != HALT_PC_OK) ? 3'd3 : 3'd0;
                    v.cyc = k;
                    v.ret = ret_sum + int'(r);
                    got = 1;
                end else if (k == MAXC) begin
                    v = '{st: 3'd4, err: 3'd2, cyc: MAXC, ret: ret_sum};
                    got = 1;
                end else begin
                    ret_sum += int'(r);
                end
                if (got) exp_q.push_back(v);
                @(posedge clk); #1;
                if (got) break;
            end
        end

        if (!got) begin
            check("midrun_state", 32'(state), 32'd2);
            check("midrun_cycles", 32'(cycle_count), abort_at);
            check("midrun_retires", 32'(retire_count), ret_sum);
        end else begin
            repeat (3) begin
                halt = 1'($urandom); retire = 1'($urandom); pc = 9'($urandom);
                @(posedge clk); #1;
            end
            check("sticky_state", 32'(state), 32'(v.st));
            check("sticky_done", 32'(done), 32'd1);
            check("sticky_err", 32'(err_code), 32'(v.err));
            check("sticky_cycles", 32'(cycle_count), v.cyc);
            check("sticky_retires", 32'(retire_count), v.ret);
            check("verdict_seen", exp_q.size(), 32'd0);
        end
    endtask

    initial begin
        run_scn(9'h000, 10, HALT_PC_OK, 0, 1'b1);   // retire every other edge, halt on edge 10
        run_scn(9'h005, 0, 9'h000, 0, 1'b0);        // PC not reset
        run_scn(9'h000, 0, 9'h000, 0, 1'b0);        // timeout
        run_scn(9'h000, MAXC, HALT_PC_OK, 0, 1'b0); // halt beats timeout
        run_scn(9'h000, 1, HALT_PC_OK, 0, 1'b0);    // halt on first RUN edge
        run_scn(9'h000, 30, 9'h000, 7, 1'b0);       // reset mid-RUN
        run_scn(9'h000, 5, 9'h00C, 0, 1'b0);        // halt at expected PC
        run_scn(9'h000, 5, 9'h00D, 0, 1'b0);        // halt at other PC
        repeat (25) begin
            run_scn(($urandom % 5 == 0) ? 9'($urandom_range(1, 511)) : 9'h000,
                    $urandom_range(0, 24),
                    ($urandom % 2 == 0) ? 9'h00C : 9'h00D,
                    ($urandom % 6 == 0) ? $urandom_range(1, 15) : 0,
                    1'b0);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/run_monitor.md
Name: run_monitor

Overview:
Synthesizable CPU execution monitor that replaces ad-hoc bench checks around the pipelined CPU top. After reset it checks that the PC has reset, then counts cycles and retired instructions until the CPU asserts halt. It flags a timeout if halt never arrives, and latches a sticky pass/fail verdict with an error code for LEDs or a bench. It is parametrised in PC width, counter width, reset latency and timeout depth.

Parameters:
PC_W, 9, PC width in bits.
CNT_W, 16, width of the cycle and retire counters.
RESET_PC, 0, PC value required after reset.
RST_DELAY, 1, rising edges after reset deassertion at which pc is sampled; minimum 1.
MAX_CYCLES, 1000, RUN-state cycle budget before timeout; must be at most 2^CNT_W-1.
EXPECTED_HALT_PC, 0, PC required at halt; used only with HALT_PC_CHECK_EN.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
pc  input  PC_W  current CPU program counter.
halt  input  1  CPU halted (level).
retire  input  1  one-cycle pulse per retired instruction.
state  output  3  FSM state: WAIT=1, RUN=2, PASS=3, FAIL=4.
done  output  1  high in PASS or FAIL.
pass  output  1  high in PASS only.
err_code  output  3  0 none, 1 PC not reset, 2 timeout, 3 halt PC mismatch.
cycle_count  output  CNT_W  edges spent in RUN.
retire_count  output  CNT_W  retire pulses seen in RUN.

Behaviour:
- Reset (sampled high on an edge): state=WAIT, done=0, pass=0, err_code=0, cycle_count=0, retire_count=0, delay counter=0. Reset wins over every other event and also applies mid-RUN or in PASS/FAIL.
- WAIT:
  - The delay counter increments on each edge with reset low.
  - On the RST_DELAY-th such edge, pc is sampled. pc==RESET_PC gives RUN; otherwise FAIL with err_code=1.
  - halt and retire are ignored in WAIT.
- RUN, per edge, in priority order:
  1. halt=1: go to PASS. A retire on the same edge is counted. cycle_count is incremented on this edge.
  2. cycle_count==MAX_CYCLES-1 (before increment): go to FAIL with err_code=2, and cycle_count becomes MAX_CYCLES.
  3. Otherwise cycle_count+1, plus retire_count+1 if retire=1.
- Halt wins over timeout on the same edge.
- Counters saturate at all-ones and never wrap.
- PASS/FAIL: sticky until reset. Counters are frozen. halt dropping, or further retire pulses, have no effect.
- Outputs are registered (done/pass decoded from the state register). All outputs are valid one edge after the causing event, with no combinational path from inputs to outputs.
- Verdict latency: the PC check resolves at edge RST_DELAY after reset deassertion; the halt verdict resolves on the first edge halt is sampled high in RUN.

Optional Feature:
HALT_PC_CHECK_EN.
- Defined: on a halt edge in RUN, pc is compared with EXPECTED_HALT_PC. Equal gives PASS; unequal gives FAIL with err_code=3. Counters update exactly as on a normal halt.
- Undefined: pc is ignored at halt, halt always gives PASS, and err_code=3 is never produced.

Test Plan:
- Reset 1 cycle, deassert with pc=0 and halt=0, then retire pulse every other cycle, halt=1 on RUN edge 10 -> state 1→2→3, done=1, pass=1, err_code=0, cycle_count=10, retire_count=5.
- Deassert reset with pc=9'h005 -> FAIL on the first edge, err_code=1, cycle_count=0, pass=0.
- MAX_CYCLES=20, halt held 0 -> FAIL after exactly 20 RUN edges, err_code=2, cycle_count=20; the same stimulus with halt=1 on edge 20 -> PASS (halt priority).
- RST_DELAY=3, pc=0 only from edge 3 (nonzero before), halt=1 during WAIT -> remains WAIT for edges 1-2, RUN at edge 3, PASS at edge 4, cycle_count=1.
- Reset asserted mid-RUN (cycle_count=7) and again in PASS -> next edge state=1, all counters 0, done=0, err_code=0.
- With HALT_PC_CHECK_EN and EXPECTED_HALT_PC=9'h00C: halt with pc=9'h00C -> PASS; halt with pc=9'h00D -> FAIL, err_code=3. Without the macro, the same pc=9'h00D case -> PASS.
